csr_trap_ctrl: RTL and testbench

CSR_TRAP_CTRL -- requirements
Module: csr_trap_ctrl

---
 rtl/csr_trap_ctrl.sv | 168 ++++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_ctrl
// Purpose  : Sequences machine-mode trap entry and MRET return via CSR port.
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl #(
    parameter logic [31:0] IRQ_CAUSE = 32'h8000_000B,
    parameter logic [1:0]  MPP_M     = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_valid,
    input  logic [4:0]  exc_cause,
    input  logic [31:0] exc_tval,
    input  logic [31:0] cur_pc,
    input  logic        irq_ext,
    input  logic        mret,
    input  logic [31:0] csr_rd,
    output logic        csr_we,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wd,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [11:0] c_addr_mstatus = 12'h300;
    localparam logic [11:0] c_addr_mtvec   = 12'h305;
    localparam logic [11:0] c_addr_mepc    = 12'h341;
    localparam logic [11:0] c_addr_mcause  = 12'h342;
    localparam logic [11:0] c_addr_mtval   = 12'h343;
    localparam logic [31:0] c_align_mask   = 32'hFFFF_FFFC;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        W_EPC    = 4'd1,
        W_CAUSE  = 4'd2,
        W_TVAL   = 4'd3,
        W_STATUS = 4'd4,
        RD_TVEC  = 4'd5,
        M_STATUS = 4'd6,
        RD_EPC   = 4'd7
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;

    logic        take_exc;
    logic        take_irq;
    logic        take_mret;

    // rst_n gates acceptance so stall stays low while reset is held.
    always_comb begin
        take_exc  = 1'b0;
        take_irq  = 1'b0;
        take_mret = 1'b0;
        if (rst_n && (state_q == IDLE)) begin
            if (exc_valid) begin
                take_exc = 1'b1;
            end else if (irq_ext && csr_rd[3]) begin
                take_irq = 1'b1;
            end else if (mret) begin
                take_mret = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cause_d     = cause_q;
        tval_d      = tval_q;
        csr_we      = 1'b0;
        csr_addr    = c_addr_mstatus;
        csr_wd      = 32'h0;
        stall       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        case (state_q)
            IDLE: begin
                stall = take_exc | take_irq | take_mret;
                if (take_exc || take_irq) begin
                    pc_d    = cur_pc;
                    cause_d = take_exc ? {27'b0, exc_cause} : IRQ_CAUSE;
                    tval_d  = take_exc ? exc_tval : 32'h0;
                    state_d = W_EPC;
                end else if (take_mret) begin
                    pc_d    = cur_pc;
                    cause_d = 32'h0;
                    tval_d  = 32'h0;
                    state_d = M_STATUS;
                end
            end
            W_EPC: begin
                csr_we   = 1'b1;
                csr_addr = c_addr_mepc;
                csr_wd   = pc_q & c_align_mask;
                state_d  = W_CAUSE;
            end
            W_CAUSE: begin
                csr_we   = 1'b1;
                csr_addr = c_addr_mcause;
                csr_wd   = cause_q;
                state_d  = W_TVAL;
            end
            W_TVAL: begin
                csr_we   = 1'b1;
                csr_addr = c_addr_mtval;
                csr_wd   = tval_q;
                state_d  = W_STATUS;
            end
            W_STATUS: begin
                // MPIE <- MIE, MIE <- 0, MPP <- machine; rest passes through.
                csr_we        = 1'b1;
                csr_addr      = c_addr_mstatus;
                csr_wd        = csr_rd;
                csr_wd[7]     = csr_rd[3];
                csr_wd[3]     = 1'b0;
                csr_wd[12:11] = MPP_M;
                state_d       = RD_TVEC;
            end
            RD_TVEC: begin
                csr_addr    = c_addr_mtvec;
                redirect    = 1'b1;
                redirect_pc = csr_rd & c_align_mask;
                state_d     = IDLE;
            end
            M_STATUS: begin
                csr_we    = 1'b1;
                csr_addr  = c_addr_mstatus;
                csr_wd    = csr_rd;
                csr_wd[3] = csr_rd[7];
                csr_wd[7] = 1'b1;
                state_d   = RD_EPC;
            end
            RD_EPC: begin
                csr_addr    = c_addr_mepc;
                redirect    = 1'b1;
                redirect_pc = csr_rd;
                state_d     = IDLE;
            end
            default: begin
                stall   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= 32'h0;
            cause_q <= 32'h0;
            tval_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_ctrl
// Purpose  : Directed and randomized self-checking bench for csr_trap_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid;
    logic [4:0]  exc_cause;
    logic [31:0] exc_tval;
    logic [31:0] cur_pc;
    logic        irq_ext;
    logic        mret;
    logic [31:0] csr_rd;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wd;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    // CSR file owned by the stimulus process.
    logic [31:0] m_status, m_tvec, m_epc, m_cause, m_tval;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected per-cycle behaviour of one event, index 0 = acceptance cycle.
    int          n_exp;
    logic        e_we    [8];
    logic [11:0] e_addr  [8];
    logic [31:0] e_wd    [8];
    logic        e_rdr   [8];
    logic [31:0] e_rpc   [8];
    logic        e_stall [8];

    always #5 clk = ~clk;

    csr_trap_ctrl #(
        .IRQ_CAUSE (32'h8000_000B),
        .MPP_M     (2'b11)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exc_valid   (exc_valid),
        .exc_cause   (exc_cause),
        .exc_tval    (exc_tval),
        .cur_pc      (cur_pc),
        .irq_ext     (irq_ext),
        .mret        (mret),
        .csr_rd      (csr_rd),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wd      (csr_wd),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always_comb begin
        case (csr_addr)
            12'h300: csr_rd = m_status;
            12'h305: csr_rd = m_tvec;
            12'h341: csr_rd = m_epc;
            12'h342: csr_rd = m_cause;
            12'h343: csr_rd = m_tval;
            default: csr_rd = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input int k, input logic we, input logic [11:0] addr,
                           input logic [31:0] wd, input logic rdr, input logic [31:0] rpc,
                           input logic stl);
        e_we[k]    = we;
        e_addr[k]  = addr;
        e_wd[k]    = wd;
        e_rdr[k]   = rdr;
        e_rpc[k]   = rpc;
        e_stall[k] = stl;
    endtask

    // Reference: derive the whole event from the architectural trap rules.
    task automatic plan(input logic exc, input logic irq, input logic mr,
                        input logic [4:0] cause, input logic [31:0] tval, input logic [31:0] pc);
        logic [31:0] st, c, t;
        n_exp = 1;
        set_exp(0, 1'b0, 12'h300, 32'h0, 1'b0, 32'h0, 1'b0);
        if (exc || (irq && m_status[3])) begin
            c  = exc ? {27'b0, cause} : 32'h8000_000B;
            t  = exc ? tval : 32'h0;
            st = m_status;
            st[7]     = m_status[3];
            st[3]     = 1'b0;
            st[12:11] = 2'b11;
            set_exp(0, 1'b0, 12'h300, 32'h0, 1'b0, 32'h0, 1'b1);
            set_exp(1, 1'b1, 12'h341, {pc[31:2], 2'b00}, 1'b0, 32'h0, 1'b1);
            set_exp(2, 1'b1, 12'h342, c, 1'b0, 32'h0, 1'b1);
            set_exp(3, 1'b1, 12'h343, t, 1'b0, 32'h0, 1'b1);
            set_exp(4, 1'b1, 12'h300, st, 1'b0, 32'h0, 1'b1);
            set_exp(5, 1'b0, 12'h305, 32'h0, 1'b1, {m_tvec[31:2], 2'b00}, 1'b1);
            n_exp = 6;
        end else if (mr) begin
            st = m_status;
            st[3] = m_status[7];
            st[7] = 1'b1;
            set_exp(0, 1'b0, 12'h300, 32'h0, 1'b0, 32'h0, 1'b1);
            set_exp(1, 1'b1, 12'h300, st, 1'b0, 32'h0, 1'b1);
            set_exp(2, 1'b0, 12'h341, 32'h0, 1'b1, m_epc, 1'b1);
            n_exp = 3;
        end
        exc_valid = exc;
        irq_ext   = irq;
        mret      = mr;
        exc_cause = cause;
        exc_tval  = tval;
        cur_pc    = pc;
    endtask

    task automatic clear_inputs();
        exc_valid = 1'b0;
        irq_ext   = 1'b0;
        mret      = 1'b0;
        exc_cause = 5'd0;
        exc_tval  = 32'h0;
        cur_pc    = 32'h0;
    endtask

    // Entered at posedge+1 of the acceptance cycle; noise drives events mid-sequence.
    task automatic run_cycles(input bit noise);
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        for (int k = 0; k < n_exp; k++) begin
            if (k > 0 && noise) begin
                exc_valid = 1'b1;
                irq_ext   = 1'($urandom_range(0, 1));
                mret      = 1'($urandom_range(0, 1));
                exc_cause = 5'($urandom_range(0, 31));
                exc_tval  = $urandom;
                cur_pc    = $urandom;
            end
            @(negedge clk);
            chk($sformatf("stall[%0d]", k), 32'(stall), 32'(e_stall[k]));
            chk($sformatf("we[%0d]", k), 32'(csr_we), 32'(e_we[k]));
            chk($sformatf("addr[%0d]", k), 32'(csr_addr), 32'(e_addr[k]));
            chk($sformatf("redirect[%0d]", k), 32'(redirect), 32'(e_rdr[k]));
            if (e_we[k]) chk($sformatf("wd[%0d]", k), csr_wd, e_wd[k]);
            if (e_rdr[k]) chk($sformatf("rpc[%0d]", k), redirect_pc, e_rpc[k]);
            w = csr_we;
            a = csr_addr;
            d = csr_wd;
            @(posedge clk);
            #1;
            if (w) begin
                case (a)
                    12'h300: m_status = d;
                    12'h305: m_tvec   = d;
                    12'h341: m_epc    = d;
                    12'h342: m_cause  = d;
                    12'h343: m_tval   = d;
                    default: ;
                endcase
            end
            clear_inputs();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(csr_we), 32'h0);
        chk({tag, "_stall"}, 32'(stall), 32'h0);
        chk({tag, "_redirect"}, 32'(redirect), 32'h0);
        chk({tag, "_rpc"}, redirect_pc, 32'h0);
        chk({tag, "_wd"}, csr_wd, 32'h0);
        chk({tag, "_addr"}, 32'(csr_addr), 32'h300);
    endtask

    initial begin
        rst_n    = 1'b0;
        m_status = 32'h0;
        m_tvec   = 32'h0;
        m_epc    = 32'h0;
        m_cause  = 32'h0;
        m_tval   = 32'h0;
        clear_inputs();
        #2;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic synchronous exception.
        m_status = 32'h08;
        m_tvec   = 32'h200;
        plan(1'b1, 1'b0, 1'b0, 5'd2, 32'hDEAD_BEEF, 32'h0000_0104);
        run_cycles(1'b0);
        chk("exc_mepc", m_epc, 32'h104);
        chk("exc_mcause", m_cause, 32'h2);
        chk("exc_mtval", m_tval, 32'hDEAD_BEEF);
        chk("exc_mstatus", m_status, 32'h1880);

        // Enabled interrupt, then the held interrupt now masked.
        m_status = 32'h08;
        plan(1'b0, 1'b1, 1'b0, 5'd7, 32'h1234_5678, 32'h0000_0400);
        run_cycles(1'b0);
        chk("irq_mcause", m_cause, 32'h8000_000B);
        chk("irq_mtval", m_tval, 32'h0);
        m_status = 32'h00;
        plan(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0000_0500);
        run_cycles(1'b0);

        // MRET.
        m_status = 32'h1880;
        m_epc    = 32'h108;
        plan(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0000_0600);
        run_cycles(1'b0);
        chk("mret_mstatus", m_status, 32'h1888);

        // All three at once: exception wins, mret is dropped.
        m_status = 32'h08;
        plan(1'b1, 1'b1, 1'b1, 5'd11, 32'hCAFE_0000, 32'h0000_0700);
        run_cycles(1'b0);
        chk("pri_mcause", m_cause, 32'hB);
        plan(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        run_cycles(1'b0);

        // Exception held high throughout the sequence is ignored.
        m_status = 32'h08;
        plan(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_0055, 32'h0000_0800);
        run_cycles(1'b1);
        chk("hold_mcause", m_cause, 32'h5);

        // Reset pulsed during W_CAUSE.
        m_cause = 32'h1111_1111;
        m_tval  = 32'h2222_2222;
        plan(1'b1, 1'b0, 1'b0, 5'd3, 32'h3333_3333, 32'h0000_0900);
        n_exp = 2;
        run_cycles(1'b0);
        #2;
        exc_valid = 1'b1;
        irq_ext   = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        exc_valid = 1'b0;
        irq_ext   = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        plan(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        run_cycles(1'b0);
        chk("midrst_mcause", m_cause, 32'h1111_1111);
        chk("midrst_mtval", m_tval, 32'h2222_2222);

        // Randomized events against the reference rules.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] ev;
            m_status = $urandom;
            m_tvec   = $urandom;
            m_epc    = $urandom;
            ev       = 3'($urandom_range(0, 7));
            plan(ev[0], ev[1], ev[2], 5'($urandom_range(0, 31)), $urandom, $urandom);
            run_cycles(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
